// File: rtl/mult_div_unit_pkg.sv
//------------------------------------------------------------------------------
// Module   : mult_div_unit_pkg
// Purpose  : Shared encodings for the multi-cycle MULT/DIV unit and the control
//            FSM that waits on it (state codes, op codes, iteration count).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_div_unit_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } md_state_e;

    localparam logic OP_MULT  = 1'b0;
    localparam logic OP_DIV   = 1'b1;

    localparam int   MD_ITER  = 32;
    localparam int   MD_CNT_W = $clog2(MD_ITER);

    // Unsigned magnitude of a two's-complement word; -2^31 maps to 2^31.
    function automatic logic [31:0] md_abs(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult_div_unit.sv
//------------------------------------------------------------------------------
// Module   : mult_div_unit
// Purpose  : Signed 32x32 multiply (radix-2 Booth) and signed divide (restoring,
//            on magnitudes) sharing one adder and one 65-bit working register.
//            Owns the HI/LO result registers; 33 cycles from start to result.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    md_state_e             state_q, state_d;
    logic                  op_q, op_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]      m_q, m_d;          // multiplicand, or |divisor|
    logic [2*WIDTH:0]      w_q, w_d;          // {acc/rem, multiplier/quo, q-1}
    logic                  negq_q, negq_d;    // quotient needs negation
    logic                  negr_q, negr_d;    // remainder needs negation
    logic [WIDTH-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  dz_q, dz_d;

    logic [WIDTH-1:0]      acc, mq;
    logic                  qm1;
    logic [WIDTH:0]        add_x, add_y, add_sum, booth_pre;
    logic                  add_sub;
    logic [2*WIDTH:0]      step_w;

    assign acc = w_q[2*WIDTH:WIDTH+1];
    assign mq  = w_q[WIDTH:1];
    assign qm1 = w_q[0];

    // Shared 33-bit adder/subtractor; the guard bit keeps Booth exact when the
    // multiplicand is -2^31 and gives the borrow for the restoring trial.
    always_comb begin
        add_x   = {acc[WIDTH-1], acc};
        add_y   = {m_q[WIDTH-1], m_q};
        add_sub = mq[0] & ~qm1;
        if (op_q == OP_DIV) begin
            add_x   = {acc, mq[WIDTH-1]};
            add_y   = {1'b0, m_q};
            add_sub = 1'b1;
        end
        add_sum = add_x + (add_y ^ {(WIDTH+1){add_sub}}) + {{WIDTH{1'b0}}, add_sub};
    end

    // One iteration of the selected algorithm applied to the working register.
    always_comb begin
        booth_pre = (mq[0] ^ qm1) ? add_sum : add_x;
        step_w    = w_q;
        if (op_q == OP_MULT) begin
            // Arithmetic shift right of {acc(33b), multiplier}, dropping q-1.
            step_w = {booth_pre, mq[WIDTH-1:1], mq[0]};
        end else if (!add_sum[WIDTH]) begin
            step_w = {add_sum[WIDTH-1:0], mq[WIDTH-2:0], 1'b1, qm1};
        end else begin
            step_w = {acc[WIDTH-2:0], mq[WIDTH-1], mq[WIDTH-2:0], 1'b0, qm1};
        end
    end

    // Control FSM: operand capture, iteration sequencing and result write-back.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        w_d     = w_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mult_start) begin
                    op_d    = OP_MULT;
                    m_d     = a;
                    w_d     = {{WIDTH{1'b0}}, b, 1'b0};
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end else if (div_start) begin
                    if (b != '0) begin
                        op_d    = OP_DIV;
                        m_d     = md_abs(b);
                        w_d     = {{WIDTH{1'b0}}, md_abs(a), 1'b0};
                        negq_d  = a[WIDTH-1] ^ b[WIDTH-1];
                        negr_d  = a[WIDTH-1];
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        dz_d = 1'b1;
                    end
                end
            end
            RUN: begin
                w_d   = step_w;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == MD_CNT_W'(MD_ITER - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                if (op_q == OP_MULT) begin
                    hi_d = acc;
                    lo_d = mq;
                end else begin
                    hi_d = negr_q ? (~acc + 1'b1) : acc;
                    lo_d = negq_q ? (~mq + 1'b1) : mq;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            cnt_q   <= '0;
            m_q     <= '0;
            w_q     <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            w_q     <= w_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

`default_nettype wire
